// File: rtl/note_lane_engine.sv
// Rhythm-game note lane engine: synchronizes buttons, steps an LFSR-chosen target lane
// per note, judges presses as hit/miss and keeps score, streak and a hit-sound timer.
module note_lane_engine #(
    parameter int          LANES    = 4,
    parameter int          TICK_DIV = 50000000,
    parameter int          ROUNDS   = 16,
    parameter int          SND_LEN  = 75000000,
    parameter int          SCORE_W  = 8,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LANES-1:0]   btn,
    output logic [LANES-1:0]   lane_led,
    output logic [LANES-1:0]   btn_led,
    output logic               hit,
    output logic               miss,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] streak,
    output logic               sound_en,
    output logic               busy
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PER_W  = $clog2(TICK_DIV);
    localparam int NOTE_W = $clog2(ROUNDS + 1);
    localparam int SND_W  = $clog2(SND_LEN + 1);

    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(TICK_DIV - 1);
    localparam logic [NOTE_W-1:0] NOTE_LAST = NOTE_W'(ROUNDS - 1);
    localparam logic [SND_W-1:0]  SND_LOAD  = SND_W'(SND_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Button synchronizer and press-event detection
    // ------------------------------------------------------------------
    logic [LANES-1:0] sync_1, sync_2, sync_3, sync_3_d;
    logic [LANES-1:0] press_q;
    logic [2:0]       prime_cnt;
    logic             primed;

    // Events stay masked until the pipeline holds only post-reset samples, so a
    // button already held when rst drops is seen as a level, not as a press.
    assign primed = (prime_cnt == 3'd4);

    // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would chain the stages into one.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1    <= '0;
            sync_2    <= '0;
            sync_3    <= '0;
            sync_3_d  <= '0;
            press_q   <= '0;
            prime_cnt <= '0;
        end else begin
            sync_1   <= btn;
            sync_2   <= sync_1;
            sync_3   <= sync_2;
            sync_3_d <= sync_3;
            press_q  <= primed ? (sync_3 & ~sync_3_d) : '0;
            if (!primed) prime_cnt <= prime_cnt + 3'd1;
        end
    end

    assign btn_led = sync_2;

    // ------------------------------------------------------------------
    // Game FSM, LFSR, counters
    // ------------------------------------------------------------------
    state_t             state, state_nx;
    logic [15:0]        lfsr, lfsr_nx, lfsr_adv;
    logic [PER_W-1:0]   period_cnt, period_nx;
    logic [NOTE_W-1:0]  note_cnt, note_nx;
    logic [SCORE_W-1:0] score_nx, streak_nx;
    logic [SND_W-1:0]   snd_cnt, snd_nx;
    logic               hit_nx, miss_nx;
    logic               judged, is_hit;
    logic [LANES-1:0]   target;

    // x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB
    assign lfsr_adv = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign target   = LANES'(1) << lfsr[LANE_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lfsr       <= SEED;
            period_cnt <= '0;
            note_cnt   <= '0;
            score      <= '0;
            streak     <= '0;
            snd_cnt    <= '0;
            hit        <= 1'b0;
            miss       <= 1'b0;
        end else begin
            state      <= state_nx;
            lfsr       <= lfsr_nx;
            period_cnt <= period_nx;
            note_cnt   <= note_nx;
            score      <= score_nx;
            streak     <= streak_nx;
            snd_cnt    <= snd_nx;
            hit        <= hit_nx;
            miss       <= miss_nx;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned and infers a latch.
        state_nx  = state;
        lfsr_nx   = lfsr;
        period_nx = period_cnt;
        note_nx   = note_cnt;
        score_nx  = score;
        streak_nx = streak;
        snd_nx    = (snd_cnt != '0) ? snd_cnt - 1'b1 : snd_cnt;
        hit_nx    = 1'b0;
        miss_nx   = 1'b0;
        judged    = 1'b0;
        is_hit    = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx  = PLAY;
                    lfsr_nx   = lfsr_adv;
                    period_nx = '0;
                    note_nx   = '0;
                    score_nx  = '0;
                    streak_nx = '0;
                end
            end
            PLAY: begin
                // A press landing on the period-end cycle wins over the timeout
                if (press_q != '0) begin
                    judged = 1'b1;
                    is_hit = (press_q == target);
                end else if (period_cnt == PER_LAST) begin
                    judged = 1'b1;
                end

                if (judged) begin
                    if (is_hit) begin
                        hit_nx    = 1'b1;
                        score_nx  = (score == '1) ? score : score + 1'b1;
                        streak_nx = (streak == '1) ? streak : streak + 1'b1;
                        snd_nx    = SND_LOAD;
                    end else begin
                        miss_nx   = 1'b1;
                        streak_nx = '0;
                    end
                    if (note_cnt == NOTE_LAST) begin
                        state_nx = DONE;
                    end else begin
                        note_nx   = note_cnt + 1'b1;
                        period_nx = '0;
                        lfsr_nx   = lfsr_adv;
                    end
                end else begin
                    period_nx = period_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign lane_led = (state == PLAY) ? target : '0;
    assign busy     = (state == PLAY);
    assign sound_en = (snd_cnt != '0);

endmodule

// File: tb/tb_note_lane_engine.sv
// Scoreboard bench for note_lane_engine: stimulus pushes expected hit/miss events
// (cycle, score, streak); a negedge monitor pops and compares them as the DUT judges.
module tb_note_lane_engine;

    localparam int          LANES    = 4;
    localparam int          TICK_DIV = 8;
    localparam int          ROUNDS   = 4;
    localparam int          SND_LEN  = 5;
    localparam int          SCORE_W  = 8;
    localparam logic [15:0] SEED     = 16'hACE1;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [LANES-1:0]   btn;
    logic [LANES-1:0]   lane_led;
    logic [LANES-1:0]   btn_led;
    logic               hit;
    logic               miss;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] streak;
    logic               sound_en;
    logic               busy;

    note_lane_engine #(
        .LANES(LANES), .TICK_DIV(TICK_DIV), .ROUNDS(ROUNDS),
        .SND_LEN(SND_LEN), .SCORE_W(SCORE_W), .SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .btn(btn),
        .lane_led(lane_led), .btn_led(btn_led), .hit(hit), .miss(miss),
        .score(score), .streak(streak), .sound_en(sound_en), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_hit;
        int cycle;
        int score;
        int streak;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] model_lfsr;
    int          exp_score;
    int          exp_streak;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic fb;
        fb = v[15] ^ v[13] ^ v[12] ^ v[10];
        return {v[14:0], fb};
    endfunction

    function automatic logic [LANES-1:0] onehot(input logic [1:0] idx);
        logic [LANES-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

    task automatic note_start();
        model_lfsr = lfsr_step(model_lfsr);
    endtask

    task automatic judge(input bit h, input int at_cycle);
        exp_t e;
        if (h) begin
            exp_score++;
            exp_streak++;
        end else begin
            exp_streak = 0;
        end
        e.is_hit = h;
        e.cycle  = at_cycle;
        e.score  = exp_score;
        e.streak = exp_streak;
        sb.push_back(e);
    endtask

    // One-cycle button pulse; returns on the following negedge
    task automatic press(input logic [LANES-1:0] v);
        btn = v;
        tick();
        btn = '0;
    endtask

    task automatic begin_game();
        start = 1'b1;
        tick();
        start = 1'b0;
        note_start();
        exp_score  = 0;
        exp_streak = 0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_lane_led"}, lane_led, 0);
        check({tag, "_hit"}, hit, 0);
        check({tag, "_miss"}, miss, 0);
        check({tag, "_score"}, score, 0);
        check({tag, "_streak"}, streak, 0);
        check({tag, "_sound"}, sound_en, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Monitor: every judgement the DUT presents must match the oldest expectation
    always @(negedge clk) begin
        if (hit === 1'b1 || miss === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_judgement", {hit, miss}, 2'b00);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("judge_hit", hit, e.is_hit);
                check("judge_miss", miss, !e.is_hit);
                check("judge_cycle", cyc, e.cycle);
                check("judge_score", score, e.score);
                check("judge_streak", streak, e.streak);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000, required end of stimulus");
        $fatal(1);
    end

    initial begin
        logic [LANES-1:0] t1, t2, wrong;
        logic [1:0]       widx;
        bit               snd_seen, all_high;
        int               s, m, u;

        model_lfsr = SEED;
        exp_score  = 0;
        exp_streak = 0;

        // Reset with every button held; the held level must never become a press
        rst   = 1'b1;
        start = 1'b0;
        btn   = '1;
        tick();
        tick();
        check_reset_state("rst");
        check("rst_btn_led", btn_led, 0);

        // Game 1: start on the release cycle, buttons held, no presses -> four timeouts
        rst = 1'b0;
        begin_game();
        snd_seen = 1'b0;
        for (int n = 0; n < ROUNDS; n++) begin
            check("g1_lane", lane_led, onehot(model_lfsr[1:0]));
            judge(1'b0, cyc + TICK_DIV);
            repeat (TICK_DIV) begin
                tick();
                snd_seen |= sound_en;
            end
            if (n < ROUNDS - 1) note_start();
        end
        check("g1_busy_done", busy, 0);
        check("g1_score", score, 0);
        check("g1_lane_done", lane_led, 0);
        check("g1_no_sound", snd_seen, 0);
        check("g1_btn_led", btn_led, 4'hF);
        btn = '0;
        repeat (4) tick();

        // Game 2: hit every note; the last press lands on the period-end cycle
        begin_game();
        for (int n = 0; n < ROUNDS; n++) begin
            check("g2_lane", lane_led, onehot(model_lfsr[1:0]));
            check("g2_busy", busy, 1);
            if (n == ROUNDS - 1) repeat (3) tick();
            judge(1'b1, cyc + 5);
            press(onehot(model_lfsr[1:0]));
            repeat (4) tick();
            if (n < ROUNDS - 1) note_start();
        end
        check("g2_busy_done", busy, 0);
        check("g2_score", score, 4);
        check("g2_streak", streak, 4);
        check("g2_sound_into_done", sound_en, 1);
        repeat (3) tick();
        check("g2_score_hold", score, 4);

        // Game 3: start held high throughout; hit, then wrong lane, then timeouts
        start = 1'b1;
        tick();
        note_start();
        exp_score  = 0;
        exp_streak = 0;
        judge(1'b1, cyc + 5);
        press(onehot(model_lfsr[1:0]));
        repeat (4) tick();
        note_start();
        check("g3_streak_after_hit", streak, 1);
        widx  = model_lfsr[1:0] + 2'd1;
        wrong = onehot(widx);
        judge(1'b0, cyc + 5);
        press(wrong);
        repeat (4) tick();
        note_start();
        m = cyc;
        check("g3_streak_cleared", streak, 0);
        check("g3_score_kept", score, 1);
        judge(1'b0, m + TICK_DIV);
        repeat (TICK_DIV) tick();
        note_start();
        judge(1'b0, m + 2 * TICK_DIV);
        repeat (TICK_DIV) tick();
        check("g3_busy_done", busy, 0);
        check("g3_score_done", score, 1);

        // Held start restarts one cycle after DONE entry -> game 4
        tick();
        start = 1'b0;
        note_start();
        exp_score  = 0;
        exp_streak = 0;
        s = cyc;
        check("g4_restart_busy", busy, 1);
        check("g4_score_cleared", score, 0);
        check("g4_lane", lane_led, onehot(model_lfsr[1:0]));

        // Two hits two cycles apart keep sound_en continuous
        t1 = onehot(model_lfsr[1:0]);
        judge(1'b1, s + 5);
        note_start();
        t2 = onehot(model_lfsr[1:0]);
        judge(1'b1, s + 7);
        note_start();
        judge(1'b0, s + 7 + TICK_DIV);
        note_start();
        judge(1'b0, s + 7 + 2 * TICK_DIV);
        btn = t1;
        tick();
        btn = '0;
        tick();
        btn = t2;
        tick();
        btn = '0;
        while (cyc < s + 5) tick();
        all_high = 1'b1;
        while (cyc < s + 12) begin
            if (sound_en !== 1'b1) all_high = 1'b0;
            tick();
        end
        check("g4_sound_continuous", all_high, 1);
        check("g4_sound_fall", sound_en, 0);
        while (cyc < s + 7 + 2 * TICK_DIV) tick();
        check("g4_busy_done", busy, 0);
        check("g4_score", score, 2);

        // Game 5: reset mid-game during note 3 while the hit sound plays
        tick();
        begin_game();
        u = cyc;
        judge(1'b1, u + 5);
        press(onehot(model_lfsr[1:0]));
        repeat (4) tick();
        note_start();
        judge(1'b1, u + 10);
        press(onehot(model_lfsr[1:0]));
        repeat (4) tick();
        note_start();
        tick();
        check("g5_sound_before_rst", sound_en, 1);
        check("g5_busy_before_rst", busy, 1);
        rst = 1'b1;
        tick();
        check_reset_state("g5_rst");
        rst = 1'b0;
        repeat (3) tick();
        check("g5_idle_after_rst", busy, 0);

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/note_lane_engine.md
NOTE_LANE_ENGINE -- requirements
Module: note_lane_engine

Interface
REQ-001 SHALL have parameter LANES, default 4, number of note lanes/buttons/LEDs; legal values 2, 4, 8.
REQ-002 SHALL have parameter TICK_DIV, default 50000000, clk cycles per note period; minimum 4.
REQ-003 SHALL have parameter ROUNDS, default 16, notes per game; minimum 1.
REQ-004 SHALL have parameter SND_LEN, default 75000000, clk cycles sound_en stays high after a hit; minimum 1.
REQ-005 SHALL have parameter SCORE_W, default 8, width of score and streak.
REQ-006 SHALL have parameter SEED, default 16'hACE1, nonzero LFSR reset value.
REQ-007 clk  in  1  system clock; all state changes on rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 start  in  1  level; starts a game from IDLE or DONE.
REQ-010 btn  in  LANES  raw asynchronous buttons, active-high, bit i = lane i.
REQ-011 lane_led  out  LANES  one-hot target lane during PLAY, zero otherwise.
REQ-012 btn_led  out  LANES  synchronized button levels (mirror of btn after sync).
REQ-013 hit  out  1  one-cycle pulse on correct press.
REQ-014 miss  out  1  one-cycle pulse on wrong press or timeout.
REQ-015 score  out  SCORE_W  hit count, saturating at all-ones.
REQ-016 streak  out  SCORE_W  consecutive hits, saturating, cleared on miss.
REQ-017 sound_en  out  1  high while hit sound plays.
REQ-018 busy  out  1  high in PLAY state.

Function
REQ-019 btn SHALL pass a 2-flop synchronizer; a press event for lane i is a 0->1 transition of the synchronized bit, registered once (third stage).
REQ-020 hit/miss for a press SHALL assert exactly 4 clk edges after the edge at which btn is first sampled high.
REQ-021 FSM states SHALL be IDLE, PLAY, DONE; IDLE->PLAY and DONE->PLAY when start=1; PLAY->DONE after ROUNDS judged notes.
REQ-022 Entering PLAY SHALL clear score, streak, note counter and period counter, and advance the LFSR once to select the first target.
REQ-023 LFSR SHALL be 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, advancing once per note start; target lane = lfsr[log2(LANES)-1:0].
REQ-024 Each note SHALL last until judged or until the period counter reaches TICK_DIV-1, whichever first; exactly one judgement per note.
REQ-025 Judgement: press event whose event vector equals the target one-hot -> hit; any other nonzero event vector (wrong lane or multiple lanes) -> miss; no event by period end -> miss.
REQ-026 After judgement, next note SHALL start on the following cycle (new target, period counter 0), unless ROUNDS reached.
REQ-027 Press event on the same cycle as period end SHALL be judged as a press; no additional timeout miss.
REQ-028 Press events in IDLE/DONE SHALL be ignored (no hit/miss, no score change).
REQ-029 On hit: score+1 and streak+1 (each saturating), sound counter loaded with SND_LEN; on miss: streak=0, score unchanged.
REQ-030 sound_en SHALL be high while sound counter nonzero, counting down per cycle; a new hit reloads SND_LEN (retrigger); continues into DONE.
REQ-031 score/streak SHALL hold in DONE until next start or rst.
REQ-032 start held high through PLAY SHALL have no effect; held high at DONE entry SHALL restart on next cycle.

Reset
REQ-033 rst SHALL force IDLE, lane_led=0, hit=0, miss=0, score=0, streak=0, sound_en=0, busy=0, lfsr=SEED, sync flops 0, all counters 0, on the clk edge it is sampled, including mid-game and mid-sound.
REQ-034 Button held high through rst release SHALL not produce a press event.

Verification (LANES=4, TICK_DIV=8, ROUNDS=4, SND_LEN=5)
REQ-035 rst, start pulse, then press lane_led lane within each period -> 4 hit pulses, score=4, streak=4, DONE, busy=0.
REQ-036 No presses after start -> miss every 8 cycles, 4 misses total, score=0, sound_en never high.
REQ-037 Press wrong lane on note 2 after hit on note 1 -> hit, then miss 4 cycles after press; streak 1->0, score=1.
REQ-038 Two hits 2 cycles apart -> sound_en continuous, falling exactly 5 cycles after second hit.
REQ-039 Assert rst at note 3 with sound_en high -> next cycle IDLE, score=0, sound_en=0, lane_led=0.
REQ-040 Press timed so event coincides with period-end cycle on correct lane -> single hit, no miss.
